uart_tx_fifo: RTL and testbench

UART transmitter with a small byte FIFO, the transmit companion to the receiver on the control link. It serialises 8-bit bytes as 1 start bit, 8 data bits LSB-first, an optional even-parity bit, and 1 stop bit on `o_Tx_Serial`. A ready/valid write port lets host logic queue up to `FIFO_DEPTH` bytes, which go out back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_byte_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: encodings and defaults shared by the control-link UART blocks.
// The TX state encoding is 3 bits wide so that the parity state can be present
// or absent without renumbering the other states.
package uart_pkg;

    // Oscillator cycles per bit for the production baud rate.
    localparam int DEFAULT_CLKS_PER_BIT = 1155;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: small byte queue feeding the UART transmitter.
// Read data comes from the storage registers at the head pointer, so it is
// stable ahead of the pop edge and can be loaded by the consumer on that edge.
// The full flag is registered, so a push is refused while full even if a pop
// happens on the same edge.
module uart_byte_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [7:0]                    data_i,
    input  logic                          pop_i,
    output logic [7:0]                    data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);

    // Occupancy tracks push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
        end
    end

    // Storage captures the input byte on acceptance; no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter (start, 8 data LSB-first, stop) fed by a
// byte FIFO. Queued bytes leave back-to-back: the stop-bit wrap pops the next
// byte and drives the next start bit on the same edge.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit; it must match the receiver build.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          osc_clk,
    input  logic                          i_Rst_L,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d, idx_nxt;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             cnt_wrap;
    logic             fifo_pop, fifo_empty, fifo_full;
    logic [7:0]       fifo_rdata;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    uart_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (osc_clk),
        .rst_ni  (i_Rst_L),
        .push_i  (i_Tx_DV),
        .data_i  (i_Tx_Byte),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (o_Fifo_Count)
    );

    assign cnt_wrap = (cnt_q == CNT_MAX);
    assign idx_nxt  = idx_q + 3'd1;

    // State register.
    always_ff @(posedge osc_clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state: every bit state advances only on the bit-counter wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_START;
            S_START: if (cnt_wrap) state_d = S_DATA;
            S_DATA: begin
                if (cnt_wrap && idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (cnt_wrap) state_d = S_STOP;
`endif
            S_STOP:  if (cnt_wrap) state_d = fifo_empty ? S_IDLE : S_START;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values: line level, pops, bit timing, done.
    always_comb begin
        fifo_pop = 1'b0;
        tx_d     = tx_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d    = ^fifo_rdata;
`endif
                end
            end
            S_START: if (cnt_wrap) tx_d = shift_q[0];
            S_DATA: begin
                if (cnt_wrap) begin
                    idx_d = idx_nxt;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d = par_q;
`else
                        tx_d = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[idx_nxt];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (cnt_wrap) tx_d = 1'b1;
`endif
            S_STOP: begin
                if (cnt_wrap) begin
                    done_d = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_d    = ^fifo_rdata;
`endif
                    end else begin
                        tx_d = 1'b1;
                    end
                end
            end
            default: tx_d = 1'b1;
        endcase
    end

    // Datapath registers; reset forces the line high immediately.
    always_ff @(posedge osc_clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte being shifted, captured when it is popped.
    always_ff @(posedge osc_clk or negedge i_Rst_L) begin
        if (!i_Rst_L) par_q <= 1'b0;
        else          par_q <= par_d;
    end
`endif

    assign o_Tx_Serial = tx_q;
    assign o_Tx_Done   = done_q;
    assign o_Tx_Active = (state_q != S_IDLE);
    assign o_Tx_Ready  = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo at CLKS_PER_BIT=8,
// FIFO_DEPTH=4, with a line receiver that rebuilds the transmitted bytes.
module tb_uart_tx_fifo;

    localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME   = 11;
    localparam int PAR_PH  = 4 + 9 * CPB;
    localparam int STOP_PH = 4 + 10 * CPB;
`else
    localparam int FRAME   = 10;
    localparam int PAR_PH  = -1;
    localparam int STOP_PH = 4 + 9 * CPB;
`endif

    logic       osc_clk;
    logic       i_Rst_L;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
    logic [2:0] o_Fifo_Count;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .osc_clk      (osc_clk),
        .i_Rst_L      (i_Rst_L),
        .i_Tx_DV      (i_Tx_DV),
        .i_Tx_Byte    (i_Tx_Byte),
        .o_Tx_Ready   (o_Tx_Ready),
        .o_Tx_Serial  (o_Tx_Serial),
        .o_Tx_Active  (o_Tx_Active),
        .o_Tx_Done    (o_Tx_Done),
        .o_Fifo_Count (o_Fifo_Count)
    );

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    int n_vec = 0;
    int n_err = 0;
    int done_n = 0;
    logic [7:0] rxq[$];
    logic       rx_par;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge osc_clk);
        #1;
    endtask

    task automatic wait_done(output int n, input int lim);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_Tx_Done && n < lim);
        if (!o_Tx_Done) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_rx(input string tag, input logic [7:0] exp);
        if (rxq.size() == 0) chk({tag, "_missing"}, 0, 1);
        else chk(tag, rxq.pop_front(), exp);
    endtask

    // Done pulse counter.
    initial forever begin
        @(negedge osc_clk);
        if (o_Tx_Done) done_n++;
    end

    // Line receiver: samples each bit at its centre, starting from the falling edge.
    initial begin
        int ph;
        bit busy;
        logic [7:0] sh;
        busy = 0; ph = 0; sh = '0; rx_par = 1'b0;
        forever begin
            @(negedge osc_clk);
            if (!i_Rst_L) busy = 0;
            else if (!busy) begin
                if (!o_Tx_Serial) begin busy = 1; ph = 0; end
            end else begin
                ph++;
                if (ph == 4) chk("rx_start", o_Tx_Serial, 0);
                else if (ph >= 12 && ph <= 68 && (ph % 8) == 4) sh[(ph - 12) / 8] = o_Tx_Serial;
                else if (ph == PAR_PH) rx_par = o_Tx_Serial;
                else if (ph == STOP_PH) begin
                    chk("rx_stop", o_Tx_Serial, 1);
                    rxq.push_back(sh);
                    busy = 0;
                end
            end
        end
    end

    initial begin
        int n, d0;
        logic [7:0] fb [5];
        int         fc [5];
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        fc = '{1, 1, 2, 3, 4};

        i_Rst_L = 1'b0; i_Tx_DV = 1'b0; i_Tx_Byte = 8'h00;
        repeat (2) @(posedge osc_clk);
        #1;
        chk("rst_serial", o_Tx_Serial, 1);
        chk("rst_ready", o_Tx_Ready, 1);
        chk("rst_active", o_Tx_Active, 0);
        chk("rst_done", o_Tx_Done, 0);
        chk("rst_count", o_Fifo_Count, 0);
        i_Rst_L = 1'b1;
        repeat (2) tick();

        // Single byte 0xA5 into an idle block.
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'hA5;
        tick();
        i_Tx_DV = 1'b0; i_Tx_Byte = 8'h00;
        chk("a5_count_n", o_Fifo_Count, 1);
        chk("a5_line_n", o_Tx_Serial, 1);
        tick();
        chk("a5_line_n1", o_Tx_Serial, 0);
        chk("a5_active_n1", o_Tx_Active, 1);
        chk("a5_count_n1", o_Fifo_Count, 0);
        wait_done(n, 200);
        chk("a5_frame_len", n, FRAME * CPB);
        chk("a5_active_end", o_Tx_Active, 0);
        chk("a5_line_end", o_Tx_Serial, 1);
        tick();
        chk("a5_done_1cyc", o_Tx_Done, 0);
        chk_rx("a5_rx", 8'hA5);

        // Three bytes on consecutive edges go out back-to-back.
        repeat (3) tick();
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'h00;
        tick();
        chk("b2b_cnt0", o_Fifo_Count, 1);
        i_Tx_Byte = 8'hFF;
        tick();
        chk("b2b_cnt1", o_Fifo_Count, 1);
        i_Tx_Byte = 8'h3C;
        tick();
        i_Tx_DV = 1'b0;
        chk("b2b_cnt2", o_Fifo_Count, 2);
        wait_done(n, 200);
        chk("b2b_gap0", n, FRAME * CPB - 1);
        chk("b2b_cnt_d0", o_Fifo_Count, 1);
        chk("b2b_line_d0", o_Tx_Serial, 0);
        wait_done(n, 200);
        chk("b2b_gap1", n, FRAME * CPB);
        chk("b2b_cnt_d1", o_Fifo_Count, 0);
        wait_done(n, 200);
        chk("b2b_gap2", n, FRAME * CPB);
        chk("b2b_active_end", o_Tx_Active, 0);
        chk_rx("b2b_rx0", 8'h00);
        chk_rx("b2b_rx1", 8'hFF);
        chk_rx("b2b_rx2", 8'h3C);

        // Fill the FIFO while the first frame shifts, then write while full.
        repeat (3) tick();
        i_Tx_DV = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_Tx_Byte = fb[i];
            tick();
            chk($sformatf("full_cnt%0d", i), o_Fifo_Count, fc[i]);
        end
        chk("full_ready", o_Tx_Ready, 0);
        i_Tx_Byte = 8'h77;
        tick();
        chk("full_drop_cnt", o_Fifo_Count, 4);
        chk("full_drop_rdy", o_Tx_Ready, 0);
        // Strobe stays high through the pop edge; that write must be dropped.
        wait_done(n, 200);
        i_Tx_DV = 1'b0;
        chk("full_pop_cnt", o_Fifo_Count, 3);
        chk("full_pop_rdy", o_Tx_Ready, 1);
        for (int i = 0; i < 4; i++) wait_done(n, 200);
        tick();
        chk("full_end_cnt", o_Fifo_Count, 0);
        chk("full_end_active", o_Tx_Active, 0);
        for (int i = 0; i < 5; i++) chk_rx($sformatf("full_rx%0d", i), fb[i]);
        chk("full_no77", rxq.size(), 0);

        // Reset in the middle of the data bits with a byte still queued.
        repeat (3) tick();
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'h5A;
        tick();
        i_Tx_Byte = 8'hC3;
        tick();
        i_Tx_DV = 1'b0;
        repeat (30) tick();
        chk("mid_line_low", o_Tx_Serial, 0);
        #2;
        d0 = done_n;
        i_Rst_L = 1'b0;
        #1;
        chk("mid_rst_line", o_Tx_Serial, 1);
        chk("mid_rst_cnt", o_Fifo_Count, 0);
        chk("mid_rst_active", o_Tx_Active, 0);
        repeat (3) @(posedge osc_clk);
        #1;
        i_Rst_L = 1'b1;
        repeat (100) tick();
        chk("mid_no_done", done_n, d0);
        chk("mid_no_rx", rxq.size(), 0);
        chk("mid_idle_line", o_Tx_Serial, 1);
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'h96;
        tick();
        i_Tx_DV = 1'b0;
        wait_done(n, 200);
        chk("post_len", n, FRAME * CPB + 1);
        chk_rx("post_rx", 8'h96);
        chk("post_rx_only", rxq.size(), 0);

`ifdef UART_TX_PARITY_EN
        // Even parity bit.
        repeat (3) tick();
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'h07;
        tick();
        i_Tx_DV = 1'b0;
        wait_done(n, 200);
        chk("par07_len", n, 88 + 1);
        chk("par07_bit", rx_par, 1);
        chk_rx("par07_rx", 8'h07);
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'h03;
        tick();
        i_Tx_DV = 1'b0;
        wait_done(n, 200);
        chk("par03_len", n, 88 + 1);
        chk("par03_bit", rx_par, 0);
        chk_rx("par03_rx", 8'h03);
`endif

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
